// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage load/store unit.
// Issues one data-memory access per memory instruction, stalls upstream
// stages while it waits for dmem_ack, aborts after TIMEOUT wait cycles,
// and registers the MEM/WB outputs.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    input  logic [1:0]  crt_wb_in,
    input  logic [4:0]  crt_mem_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] dato_b_in,
    input  logic [4:0]  rd_in,

    output logic        stall_out,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,

    output logic        out_valid,
    output logic [1:0]  crt_wb_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;

    // Operation latched on entry to ACCESS
    logic           op_we_q;
    logic [2:0]     op_f3_q;
    logic [1:0]     op_lo_q;
    logic [1:0]     op_wb_q;
    logic [31:0]    op_alu_q;
    logic [4:0]     op_rd_q;

    // Decoded incoming instruction
    logic           mem_read;
    logic           mem_write;
    logic [2:0]     funct3;
    logic           is_mem;
    logic           misaligned;
    logic [3:0]     be_calc;
    logic [31:0]    wdata_calc;
    logic [31:0]    load_data;
    logic [31:0]    lane;

    // Decode control field, alignment check and store lane/byte-enable setup
    always_comb begin
        mem_read   = crt_mem_in[0];
        mem_write  = crt_mem_in[1];
        funct3     = crt_mem_in[4:2];
        is_mem     = mem_read | mem_write;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = '0;
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_result_in[0];
            default: misaligned = (alu_result_in[1:0] != 2'b00);
        endcase
        // Read+write together is treated as a write
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    be_calc    = 4'b0001 << alu_result_in[1:0];
                    wdata_calc = {4{dato_b_in[7:0]}};
                end
                2'b01: begin
                    be_calc    = 4'b0011 << {alu_result_in[1], 1'b0};
                    wdata_calc = {2{dato_b_in[15:0]}};
                end
                default: begin
                    be_calc    = 4'b1111;
                    wdata_calc = dato_b_in;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension from the returned word
    always_comb begin
        lane      = dmem_rdata >> {op_lo_q, 3'b000};
        load_data = dmem_rdata;
        case (op_f3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_data = {24'h000000, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_data = {16'h0000, lane[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // Stall and bus strobes derived from state and current inputs
    always_comb begin
        dmem_req  = (state == ACCESS);
        dmem_we   = (state == ACCESS) && op_we_q;
        stall_out = 1'b0;
        if (!rst) begin
            if (state == IDLE)
                stall_out = in_valid && is_mem && !misaligned;
            else
                stall_out = !dmem_ack && (cnt != TO_CNT);
        end
    end

    // FSM, memory request registers and MEM/WB output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            op_we_q        <= 1'b0;
            op_f3_q        <= '0;
            op_lo_q        <= '0;
            op_wb_q        <= '0;
            op_alu_q       <= '0;
            op_rd_q        <= '0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            out_valid      <= 1'b0;
            crt_wb_out     <= '0;
            mem_data_out   <= '0;
            alu_result_out <= '0;
            rd_out         <= '0;
            misalign_out   <= 1'b0;
            bus_err_out    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            out_valid      <= 1'b1;
                            crt_wb_out     <= crt_wb_in;
                            alu_result_out <= alu_result_in;
                            rd_out         <= rd_in;
                            mem_data_out   <= '0;
                            misalign_out   <= 1'b0;
                            bus_err_out    <= 1'b0;
                        end else if (misaligned) begin
                            out_valid      <= 1'b1;
                            crt_wb_out     <= '0;
                            alu_result_out <= alu_result_in;
                            rd_out         <= rd_in;
                            mem_data_out   <= '0;
                            misalign_out   <= 1'b1;
                            bus_err_out    <= 1'b0;
                        end else begin
                            op_we_q    <= mem_write;
                            op_f3_q    <= funct3;
                            op_lo_q    <= alu_result_in[1:0];
                            op_wb_q    <= crt_wb_in;
                            op_alu_q   <= alu_result_in;
                            op_rd_q    <= rd_in;
                            dmem_addr  <= {alu_result_in[31:2], 2'b00};
                            dmem_be    <= be_calc;
                            dmem_wdata <= wdata_calc;
                            cnt        <= '0;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a coincident timeout
                    if (dmem_ack) begin
                        out_valid      <= 1'b1;
                        crt_wb_out     <= op_wb_q;
                        alu_result_out <= op_alu_q;
                        rd_out         <= op_rd_q;
                        mem_data_out   <= op_we_q ? '0 : load_data;
                        misalign_out   <= 1'b0;
                        bus_err_out    <= 1'b0;
                        state          <= IDLE;
                    end else if (cnt == TO_CNT) begin
                        out_valid      <= 1'b1;
                        crt_wb_out     <= '0;
                        alu_result_out <= op_alu_q;
                        rd_out         <= op_rd_q;
                        mem_data_out   <= '0;
                        misalign_out   <= 1'b0;
                        bus_err_out    <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu (TIMEOUT=4).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  crt_wb_in;
    logic [4:0]  crt_mem_in;
    logic [31:0] alu_result_in;
    logic [31:0] dato_b_in;
    logic [4:0]  rd_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [1:0]  crt_wb_out;
    logic [31:0] mem_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        misalign_out;
    logic        bus_err_out;

    int total = 0;
    int bad   = 0;

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .crt_wb_in(crt_wb_in), .crt_mem_in(crt_mem_in),
        .alu_result_in(alu_result_in), .dato_b_in(dato_b_in), .rd_in(rd_in),
        .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .crt_wb_out(crt_wb_out), .mem_data_out(mem_data_out),
        .alu_result_out(alu_result_out), .rd_out(rd_out),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".crt_wb"}, 32'(crt_wb_out), 32'd0);
        chk({tag, ".mem_data"}, mem_data_out, 32'd0);
        chk({tag, ".alu"}, alu_result_out, 32'd0);
        chk({tag, ".rd"}, 32'(rd_out), 32'd0);
        chk({tag, ".misalign"}, 32'(misalign_out), 32'd0);
        chk({tag, ".bus_err"}, 32'(bus_err_out), 32'd0);
        chk({tag, ".req"}, 32'(dmem_req), 32'd0);
        chk({tag, ".we"}, 32'(dmem_we), 32'd0);
        chk({tag, ".be"}, 32'(dmem_be), 32'd0);
        chk({tag, ".addr"}, dmem_addr, 32'd0);
        chk({tag, ".wdata"}, dmem_wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; crt_wb_in = '0; crt_mem_in = '0;
        alu_result_in = '0; dato_b_in = '0; rd_in = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // ALU op, single-cycle, no stall
        in_valid = 1'b1; crt_wb_in = 2'b11; crt_mem_in = 5'b00000;
        alu_result_in = 32'h12345678; rd_in = 5'd5;
        #1 chk("alu.stall", 32'(stall_out), 32'd0);
        tick();
        chk("alu.valid", 32'(out_valid), 32'd1);
        chk("alu.result", alu_result_out, 32'h12345678);
        chk("alu.rd", 32'(rd_out), 32'd5);
        chk("alu.wb", 32'(crt_wb_out), 32'd3);
        chk("alu.mem_data", mem_data_out, 32'd0);
        chk("alu.misalign", 32'(misalign_out), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("idle.valid", 32'(out_valid), 32'd0);
        chk("idle.hold", alu_result_out, 32'h12345678);

        // LB 0x1003, ack two cycles after req
        in_valid = 1'b1; crt_wb_in = 2'b01; crt_mem_in = 5'b00001;
        alu_result_in = 32'h00001003; rd_in = 5'd7; dmem_rdata = 32'h80FFFF00;
        #1 chk("lb.stall0", 32'(stall_out), 32'd1);
        chk("lb.req_idle", 32'(dmem_req), 32'd0);
        tick();
        chk("lb.req", 32'(dmem_req), 32'd1);
        chk("lb.addr", dmem_addr, 32'h00001000);
        chk("lb.we", 32'(dmem_we), 32'd0);
        chk("lb.be", 32'(dmem_be), 32'hF);
        chk("lb.stall1", 32'(stall_out), 32'd1);
        chk("lb.valid_busy", 32'(out_valid), 32'd0);
        tick();
        chk("lb.stall2", 32'(stall_out), 32'd1);
        tick();
        dmem_ack = 1'b1; in_valid = 1'b0;
        #1 chk("lb.stall_ack", 32'(stall_out), 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("lb.valid", 32'(out_valid), 32'd1);
        chk("lb.data", mem_data_out, 32'hFFFFFF80);
        chk("lb.rd", 32'(rd_out), 32'd7);
        chk("lb.wb", 32'(crt_wb_out), 32'd1);
        chk("lb.req_done", 32'(dmem_req), 32'd0);

        // LBU 0x1003, ack in first access cycle
        in_valid = 1'b1; crt_mem_in = 5'b10001;
        tick();
        in_valid = 1'b0; dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("lbu.valid", 32'(out_valid), 32'd1);
        chk("lbu.data", mem_data_out, 32'h00000080);

        // SH 0x2002
        in_valid = 1'b1; crt_wb_in = 2'b00; crt_mem_in = 5'b00110;
        alu_result_in = 32'h00002002; dato_b_in = 32'h0000BEEF; rd_in = 5'd0;
        tick();
        in_valid = 1'b0;
        chk("sh.be", 32'(dmem_be), 32'hC);
        chk("sh.wdata", dmem_wdata, 32'hBEEFBEEF);
        chk("sh.addr", dmem_addr, 32'h00002000);
        chk("sh.we", 32'(dmem_we), 32'd1);
        chk("sh.req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("sh.valid", 32'(out_valid), 32'd1);
        chk("sh.mem_data", mem_data_out, 32'd0);

        // SB with read+write both set -> write
        in_valid = 1'b1; crt_mem_in = 5'b00011;
        alu_result_in = 32'h00001001; dato_b_in = 32'h123456A5;
        tick();
        in_valid = 1'b0;
        chk("sb.be", 32'(dmem_be), 32'h2);
        chk("sb.wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb.we", 32'(dmem_we), 32'd1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("sb.mem_data", mem_data_out, 32'd0);

        // Misaligned LW 0x3001
        in_valid = 1'b1; crt_wb_in = 2'b11; crt_mem_in = 5'b01001;
        alu_result_in = 32'h00003001; rd_in = 5'd3;
        #1 chk("mis.stall", 32'(stall_out), 32'd0);
        tick();
        chk("mis.req", 32'(dmem_req), 32'd0);
        chk("mis.valid", 32'(out_valid), 32'd1);
        chk("mis.flag", 32'(misalign_out), 32'd1);
        chk("mis.wb", 32'(crt_wb_out), 32'd0);
        chk("mis.bus_err", 32'(bus_err_out), 32'd0);

        // Ack while idle is ignored
        in_valid = 1'b0; dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack.valid", 32'(out_valid), 32'd0);
        chk("idle_ack.req", 32'(dmem_req), 32'd0);

        // Timeout: LW 0x4000, no ack
        in_valid = 1'b1; crt_wb_in = 2'b11; crt_mem_in = 5'b01001;
        alu_result_in = 32'h00004000; rd_in = 5'd4;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to.stall%0d", i), 32'(stall_out), 32'd1);
            tick();
        end
        chk("to.stall_rel", 32'(stall_out), 32'd0);
        chk("to.req_last", 32'(dmem_req), 32'd1);
        tick();
        chk("to.valid", 32'(out_valid), 32'd1);
        chk("to.bus_err", 32'(bus_err_out), 32'd1);
        chk("to.wb", 32'(crt_wb_out), 32'd0);
        chk("to.misalign", 32'(misalign_out), 32'd0);
        chk("to.req", 32'(dmem_req), 32'd0);

        // Ack in the timeout cycle wins
        in_valid = 1'b1; alu_result_in = 32'h00004004; dmem_rdata = 32'hCAFEF00D;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("race.valid", 32'(out_valid), 32'd1);
        chk("race.bus_err", 32'(bus_err_out), 32'd0);
        chk("race.data", mem_data_out, 32'hCAFEF00D);
        chk("race.wb", 32'(crt_wb_out), 32'd3);

        // Reset mid-access
        in_valid = 1'b1; alu_result_in = 32'h00005000; rd_in = 5'd6;
        tick();
        chk("rstacc.req_before", 32'(dmem_req), 32'd1);
        rst = 1'b1; dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk_all_zero("rstacc");
        chk("rstacc.stall", 32'(stall_out), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rstacc.no_valid", 32'(out_valid), 32'd0);
        chk("rstacc.req_after", 32'(dmem_req), 32'd0);
        in_valid = 1'b1; crt_wb_in = 2'b10; crt_mem_in = 5'b00000;
        alu_result_in = 32'hA5A50001; rd_in = 5'd9;
        tick();
        in_valid = 1'b0;
        chk("post.valid", 32'(out_valid), 32'd1);
        chk("post.alu", alu_result_out, 32'hA5A50001);
        chk("post.rd", 32'(rd_out), 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles to wait for dmem_ack before abort.
REQ-002 SHALL have clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have in_valid  in  1, crt_wb_in  in  2, crt_mem_in  in  5, alu_result_in  in  32, dato_b_in  in  32, rd_in  in  5: the EXE/MEM register outputs.
REQ-005 SHALL decode crt_mem_in as: [0] mem_read, [1] mem_write, [4:2] funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL have stall_out  out  1  freeze upstream stages and EXE/MEM register.
REQ-007 SHALL have dmem_req  out  1, dmem_we  out  1, dmem_addr  out  32 (word-aligned, [1:0]=0), dmem_be  out  4, dmem_wdata  out  32, dmem_ack  in  1, dmem_rdata  in  32.
REQ-008 SHALL have out_valid  out  1, crt_wb_out  out  2, mem_data_out  out  32, alu_result_out  out  32, rd_out  out  5, misalign_out  out  1, bus_err_out  out  1: registered MEM/WB outputs.

Function
REQ-009 SHALL implement FSM states IDLE and ACCESS; reset state IDLE.
REQ-010 IDLE, in_valid=0: out_valid=0 at next edge; other outputs hold.
REQ-011 IDLE, in_valid=1, no read/write: next edge registers crt_wb_in, alu_result_in, rd_in to outputs, out_valid=1, mem_data_out=0; latency 1, no stall.
REQ-012 mem_write=1 and mem_read=1 together SHALL be treated as a write.
REQ-013 Misaligned = (H/HU with addr[0]=1) or (W with addr[1:0]!=0); SHALL issue no request, next edge out_valid=1, misalign_out=1, crt_wb_out=0, no stall.
REQ-014 IDLE, in_valid=1, aligned memory op: SHALL latch op, addr, data, rd, crt_wb; enter ACCESS; stall_out=1 combinationally that cycle.
REQ-015 ACCESS: dmem_req=1 (driven from state), dmem_addr={addr[31:2],2'b00}, dmem_we=mem_write; stall_out=!dmem_ack.
REQ-016 Store: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011<<{addr[1],1'b0}, wdata=half replicated x2; SW be=1111, wdata=data; loads be=1111.
REQ-017 Load extract: lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged; registered to mem_data_out at ack edge.
REQ-018 ACCESS with dmem_ack=1: next edge out_valid=1, return to IDLE; minimum memory-op latency 2 cycles; stores deliver mem_data_out=0.
REQ-019 Wait counter SHALL clear on ACCESS entry and increment each cycle without ack; at count=TIMEOUT SHALL abort: out_valid=1, bus_err_out=1, crt_wb_out=0, return to IDLE, stall_out=0 that cycle.
REQ-020 Ack arriving the same cycle as timeout SHALL win (normal completion, bus_err_out=0).
REQ-021 dmem_ack while IDLE SHALL be ignored.
REQ-022 misalign_out and bus_err_out SHALL be 0 on every out_valid not flagged by REQ-013/REQ-019.

Reset
REQ-023 On rst edge: state IDLE, counter 0, all outputs 0 (out_valid, crt_wb_out, mem_data_out, alu_result_out, rd_out, misalign_out, bus_err_out, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata).
REQ-024 rst during ACCESS SHALL abandon the access; dmem_req=0 from the cycle after the reset edge; no out_valid produced for it.
REQ-025 rst SHALL override in_valid and dmem_ack in the same cycle.

Verification
REQ-026 ALU op: in_valid=1, crt_mem=0, alu=0x12345678, rd=5 -> next cycle out_valid=1, alu_result_out=0x12345678, rd_out=5, stall_out never 1.
REQ-027 LB addr=0x1003, dmem_rdata=0x80FF_FF00, ack 2 cycles after req -> stall 3 cycles, mem_data_out=0xFFFF_FF80; same with LBU -> 0x0000_0080.
REQ-028 SH addr=0x2002, data=0x0000_BEEF -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_addr=0x2000, dmem_we=1.
REQ-029 LW addr=0x3001 -> no dmem_req, next cycle misalign_out=1, crt_wb_out=0, out_valid=1.
REQ-030 LW with ack never asserted, TIMEOUT=4 -> bus_err_out=1 after 4 wait cycles, stall released; repeat with ack on cycle 4 -> normal completion.
REQ-031 rst asserted mid-ACCESS -> dmem_req=0 next cycle, all outputs 0, FSM IDLE, subsequent ALU op completes normally.
